// File: rtl/cpu_ctrl_pkg.sv
// Shared state codes, ALU encodings and status-bit indices for the CPU control unit.
// The next-state decoder and the sequential control half both import these.
package cpu_ctrl_pkg;

  typedef logic [7:0] state_t;

  localparam state_t S_FETCH0 = 8'h00;
  localparam state_t S_EXEC   = 8'h01;
  localparam state_t S_LOAD   = 8'h02;
  localparam state_t S_MOV    = 8'h03;
  localparam state_t S_LDPC   = 8'h04;
  localparam state_t S_BR     = 8'h05;
  localparam state_t S_SUB0   = 8'h06;
  localparam state_t S_SUB1   = 8'h07;
  localparam state_t S_SUB2   = 8'h08;
  localparam state_t S_ADD0   = 8'h09;
  localparam state_t S_ADD1   = 8'h0A;
  localparam state_t S_ADD2   = 8'h0B;
  localparam state_t S_XOR0   = 8'h0C;
  localparam state_t S_XOR1   = 8'h0D;
  localparam state_t S_XOR2   = 8'h0E;
  localparam state_t S_FETCH1 = 8'h0F;
  localparam state_t S_PUSH0  = 8'h13;
  localparam state_t S_PUSH1  = 8'h14;
  localparam state_t S_PUSH2  = 8'h15;
  localparam state_t S_PUSH3  = 8'h16;
  localparam state_t S_POP0   = 8'h17;
  localparam state_t S_POP1   = 8'h18;
  localparam state_t S_POP2   = 8'h19;
  localparam state_t S_POP3   = 8'h1A;
  localparam state_t S_CALL0  = 8'h1B;
  localparam state_t S_CALL1  = 8'h1C;
  localparam state_t S_CALL2  = 8'h1D;
  localparam state_t S_CALL3  = 8'h1E;
  localparam state_t S_CALL4  = 8'h1F;
  localparam state_t S_CALL5  = 8'h20;
  localparam state_t S_RET0   = 8'h21;
  localparam state_t S_RET1   = 8'h22;
  localparam state_t S_RET2   = 8'h23;
  localparam state_t S_RET3   = 8'h24;
  localparam state_t S_CMP0   = 8'h26;
  localparam state_t S_CMP1   = 8'h27;
  localparam state_t S_BREQ1  = 8'h29;
  localparam state_t S_BREQ2  = 8'h2A;
  localparam state_t S_BREQ3  = 8'h2B;
  localparam state_t S_BREQ4  = 8'h2C;
  localparam state_t S_BRLO1  = 8'h2D;
  localparam state_t S_BRLO2  = 8'h2E;
  localparam state_t S_BRLO3  = 8'h2F;
  localparam state_t S_BRLO4  = 8'h30;
  localparam state_t S_BRHI1  = 8'h31;
  localparam state_t S_BRHI2  = 8'h32;
  localparam state_t S_BRHI3  = 8'h33;
  localparam state_t S_BRHI4  = 8'h34;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_XOR  = 2'b11;

  localparam int STAT_N = 3;
  localparam int STAT_P = 2;
  localparam int STAT_Z = 1;
  localparam int STAT_C = 0;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic       rf_we;
    logic       sp_inc;
    logic       sp_dec;
    logic [1:0] alu_op;
    logic       flag_upd;
  } strobe_t;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH1) || (s == S_LOAD) || ((s >= S_PUSH0) && (s <= S_RET3));
  endfunction

endpackage

// File: rtl/ctrl_strobe_dec.sv
// Combinational state-to-strobe decode; memory states without an acknowledge
// keep only the request/write strobes alive and report a stall.
module ctrl_strobe_dec
  import cpu_ctrl_pkg::*;
(
  input  state_t  state,
  input  logic    mem_ready,
  output strobe_t strobes,
  output logic    stall
);

  strobe_t w_raw;
  logic    w_mem;

  always_comb begin
    w_raw = '0;
    w_mem = is_mem_state(state);
    unique case (state)
      S_LOAD, S_MOV, S_LDPC, S_POP3:     w_raw.rf_we = 1'b1;
      S_ADD0, S_ADD1:                    w_raw.alu_op = ALU_ADD;
      S_ADD2: begin
        w_raw.alu_op   = ALU_ADD;
        w_raw.rf_we    = 1'b1;
        w_raw.flag_upd = 1'b1;
      end
      S_SUB0, S_SUB1, S_CMP0:            w_raw.alu_op = ALU_SUB;
      S_SUB2: begin
        w_raw.alu_op   = ALU_SUB;
        w_raw.rf_we    = 1'b1;
        w_raw.flag_upd = 1'b1;
      end
      S_CMP1: begin
        w_raw.alu_op   = ALU_SUB;
        w_raw.flag_upd = 1'b1;
      end
      S_XOR0, S_XOR1:                    w_raw.alu_op = ALU_XOR;
      S_XOR2: begin
        w_raw.alu_op   = ALU_XOR;
        w_raw.rf_we    = 1'b1;
        w_raw.flag_upd = 1'b1;
      end
      S_FETCH1: begin
        w_raw.ir_load = 1'b1;
        w_raw.pc_inc  = 1'b1;
      end
      S_BR, S_BREQ2, S_BRLO2, S_BRHI2,
      S_CALL5, S_RET3:                   w_raw.pc_load = 1'b1;
      S_PUSH2, S_CALL2, S_CALL4:         w_raw.mem_we = 1'b1;
      S_PUSH3, S_CALL1, S_CALL3:         w_raw.sp_dec = 1'b1;
      S_POP0, S_RET0, S_RET2:            w_raw.sp_inc = 1'b1;
      default: ;
    endcase
  end

  // A waiting memory state freezes everything except the request itself.
  always_comb begin
    stall           = w_mem & ~mem_ready;
    strobes         = w_raw;
    strobes.mem_req = w_mem;
    if (stall) begin
      strobes         = '0;
      strobes.mem_req = 1'b1;
      strobes.mem_we  = w_raw.mem_we;
    end
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Sequential half of the CPU control unit: state register, instruction register
// and status flags, with datapath strobes decoded from the registered state.
module cpu_ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int STATE_W = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STATE_W-1:0] next_state,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ready,
  input  logic [3:0]         alu_flags,
  output logic [STATE_W-1:0] state,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         status_reg,
  output logic               mem_req,
  output logic               mem_we,
  output logic               ir_load,
  output logic               pc_inc,
  output logic               pc_load,
  output logic               rf_we,
  output logic               sp_inc,
  output logic               sp_dec,
  output logic [1:0]         alu_op
);

  logic [STATE_W-1:0] r_state;
  logic [INSTR_W-1:0] r_instr;
  logic [3:0]         r_status;
  strobe_t            w_str;
  logic               w_stall;

  ctrl_strobe_dec u_dec (
    .state     (r_state),
    .mem_ready (mem_ready),
    .strobes   (w_str),
    .stall     (w_stall)
  );

  // IR and flags only move on an advancing edge, so a stall can never half-commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= '0;
      r_instr  <= '0;
      r_status <= '0;
    end else if (!w_stall) begin
      r_state <= next_state;
      if (w_str.ir_load)  r_instr  <= mem_rdata;
      if (w_str.flag_upd) r_status <= alu_flags;
    end
  end

  assign state      = r_state;
  assign instr      = r_instr;
  assign status_reg = r_status;
  assign mem_req    = w_str.mem_req;
  assign mem_we     = w_str.mem_we;
  assign ir_load    = w_str.ir_load;
  assign pc_inc     = w_str.pc_inc;
  assign pc_load    = w_str.pc_load;
  assign rf_we      = w_str.rf_we;
  assign sp_inc     = w_str.sp_inc;
  assign sp_dec     = w_str.sp_dec;
  assign alu_op     = w_str.alu_op;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed and randomized bench for cpu_ctrl_seq against a table-driven reference
// model built from the state/strobe lists of the control unit.
module tb_cpu_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  next_state;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [3:0]  alu_flags;
  logic [7:0]  state;
  logic [15:0] instr;
  logic [3:0]  status_reg;
  logic        mem_req, mem_we, ir_load, pc_inc, pc_load, rf_we, sp_inc, sp_dec;
  logic [1:0]  alu_op;

  int checks = 0;
  int failures = 0;

  bit       is_mem [256];
  bit       t_we   [256];
  bit       t_rf   [256];
  bit       t_pcl  [256];
  bit       t_spi  [256];
  bit       t_spd  [256];
  bit       t_flag [256];
  bit [1:0] t_alu  [256];

  logic [7:0]  m_state;
  logic [15:0] m_instr;
  logic [3:0]  m_status;

  int c_pc_inc, c_ir_load, c_rf_we, c_pc_load, c_sp_dec, c_mem_we, c_alu_add;

  logic [9:0] dut_str;
  assign dut_str = {mem_req, mem_we, ir_load, pc_inc, pc_load, rf_we, sp_inc, sp_dec, alu_op};

  cpu_ctrl_seq #(.STATE_W(8), .INSTR_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .next_state (next_state),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .alu_flags  (alu_flags),
    .state      (state),
    .instr      (instr),
    .status_reg (status_reg),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .rf_we      (rf_we),
    .sp_inc     (sp_inc),
    .sp_dec     (sp_dec),
    .alu_op     (alu_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic init_tables();
    int rf_l[7]  = '{8'h02, 8'h03, 8'h04, 8'h08, 8'h0B, 8'h0E, 8'h1A};
    int pcl_l[6] = '{8'h05, 8'h2A, 8'h2E, 8'h32, 8'h20, 8'h24};
    for (int s = 0; s < 256; s++) begin
      is_mem[s] = 1'b0; t_we[s] = 1'b0; t_rf[s] = 1'b0; t_pcl[s] = 1'b0;
      t_spi[s] = 1'b0; t_spd[s] = 1'b0; t_flag[s] = 1'b0; t_alu[s] = 2'b00;
    end
    is_mem[8'h0F] = 1'b1;
    is_mem[8'h02] = 1'b1;
    for (int s = 8'h13; s <= 8'h24; s++) is_mem[s] = 1'b1;
    t_we[8'h15] = 1'b1; t_we[8'h1D] = 1'b1; t_we[8'h1F] = 1'b1;
    foreach (rf_l[i]) t_rf[rf_l[i]] = 1'b1;
    foreach (pcl_l[i]) t_pcl[pcl_l[i]] = 1'b1;
    t_spi[8'h17] = 1'b1; t_spi[8'h21] = 1'b1; t_spi[8'h23] = 1'b1;
    t_spd[8'h16] = 1'b1; t_spd[8'h1C] = 1'b1; t_spd[8'h1E] = 1'b1;
    for (int s = 8'h09; s <= 8'h0B; s++) t_alu[s] = 2'b01;
    for (int s = 8'h06; s <= 8'h08; s++) t_alu[s] = 2'b10;
    for (int s = 8'h0C; s <= 8'h0E; s++) t_alu[s] = 2'b11;
    t_alu[8'h26] = 2'b10; t_alu[8'h27] = 2'b10;
    t_flag[8'h0B] = 1'b1; t_flag[8'h08] = 1'b1; t_flag[8'h0E] = 1'b1; t_flag[8'h27] = 1'b1;
  endtask

  function automatic logic [9:0] exp_str(input logic [7:0] s, input logic rdy);
    logic h;
    h = is_mem[s] && !rdy;
    return {is_mem[s], t_we[s], !h && (s == 8'h0F), !h && (s == 8'h0F),
            !h && t_pcl[s], !h && t_rf[s], !h && t_spi[s], !h && t_spd[s],
            h ? 2'b00 : t_alu[s]};
  endfunction

  task automatic clr_cnt();
    c_pc_inc = 0; c_ir_load = 0; c_rf_we = 0; c_pc_load = 0;
    c_sp_dec = 0; c_mem_we = 0; c_alu_add = 0;
  endtask

  // One clock: drive, check against the model mid-cycle, then advance the model.
  task automatic step(input logic [7:0] ns, input logic rdy, input logic [15:0] rd,
                      input logic [3:0] fl);
    logic h;
    next_state = ns; mem_ready = rdy; mem_rdata = rd; alu_flags = fl;
    #2;
    chk("state", 32'(state), 32'(m_state));
    chk("instr", 32'(instr), 32'(m_instr));
    chk("status", 32'(status_reg), 32'(m_status));
    chk("strobes", 32'(dut_str), 32'(exp_str(m_state, rdy)));
    c_pc_inc  += int'(pc_inc);
    c_ir_load += int'(ir_load);
    c_rf_we   += int'(rf_we);
    c_pc_load += int'(pc_load);
    c_sp_dec  += int'(sp_dec);
    c_mem_we  += int'(mem_we);
    c_alu_add += int'(alu_op == 2'b01);
    @(posedge clk);
    h = is_mem[m_state] && !rdy;
    if (!h) begin
      if (m_state == 8'h0F) m_instr = rd;
      if (t_flag[m_state]) m_status = fl;
      m_state = ns;
    end
    #1;
  endtask

  initial begin
    logic [7:0] ns;
    init_tables();
    clr_cnt();
    rst_n = 1'b0; next_state = 8'h00; mem_ready = 1'b0; mem_rdata = 16'h0; alu_flags = 4'h0;
    m_state = 8'h00; m_instr = 16'h0; m_status = 4'h0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_state", 32'(state), 32'h00);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_status", 32'(status_reg), 32'h0);
    chk("rst_strobes", 32'(dut_str), 32'h0);
    rst_n = 1'b1;

    // fetch 0x00 -> 0x0F -> 0x01 -> 0x09
    clr_cnt();
    step(8'h0F, 1'b1, 16'h2123, 4'h0);
    chk("t1_s0f", 32'(state), 32'h0F);
    step(8'h01, 1'b1, 16'h2123, 4'h0);
    chk("t1_s01", 32'(state), 32'h01);
    step(8'h09, 1'b1, 16'h2123, 4'h0);
    chk("t1_s09", 32'(state), 32'h09);
    chk("t1_instr", 32'(instr), 32'h2123);
    chk("t1_pc_inc_cnt", 32'(c_pc_inc), 32'd1);

    // add sequence
    clr_cnt();
    step(8'h0A, 1'b1, 16'h0, 4'b0010);
    step(8'h0B, 1'b1, 16'h0, 4'b0010);
    step(8'h00, 1'b1, 16'h0, 4'b0010);
    chk("t3_status", 32'(status_reg), 32'b0010);
    chk("t3_rf_we_cnt", 32'(c_rf_we), 32'd1);
    chk("t3_alu_add_cnt", 32'(c_alu_add), 32'd3);

    // fetch with three wait cycles
    clr_cnt();
    step(8'h0F, 1'b1, 16'h0, 4'h0);
    for (int i = 0; i < 3; i++) step(8'h01, 1'b0, 16'hFFFF, 4'h0);
    chk("t2_stall_state", 32'(state), 32'h0F);
    chk("t2_stall_instr", 32'(instr), 32'h2123);
    chk("t2_stall_ir_load", 32'(c_ir_load), 32'd0);
    step(8'h01, 1'b1, 16'h1D00, 4'h0);
    chk("t2_state", 32'(state), 32'h01);
    chk("t2_instr", 32'(instr), 32'h1D00);
    chk("t2_ir_load_cnt", 32'(c_ir_load), 32'd1);
    chk("t2_pc_inc_cnt", 32'(c_pc_inc), 32'd1);

    // BREQ taken (Z=1)
    clr_cnt();
    step(8'h29, 1'b1, 16'h0, 4'h0);
    step(m_status[1] ? 8'h2A : 8'h2B, 1'b1, 16'h0, 4'h0);
    chk("t4_taken_state", 32'(state), 32'h2A);
    step(8'h2C, 1'b1, 16'h0, 4'h0);
    step(8'h2B, 1'b1, 16'h0, 4'h0);
    step(8'h00, 1'b1, 16'h0, 4'h0);
    chk("t4_taken_pc_load_cnt", 32'(c_pc_load), 32'd1);
    chk("t4_taken_end", 32'(state), 32'h00);

    // compare clears Z
    step(8'h26, 1'b1, 16'h0, 4'b1001);
    step(8'h27, 1'b1, 16'h0, 4'b1001);
    step(8'h01, 1'b1, 16'h0, 4'b1001);
    chk("cmp_status", 32'(status_reg), 32'b1001);

    // BREQ not taken (Z=0)
    clr_cnt();
    step(8'h29, 1'b1, 16'h0, 4'h0);
    step(m_status[1] ? 8'h2A : 8'h2B, 1'b1, 16'h0, 4'h0);
    chk("t4_nt_state", 32'(state), 32'h2B);
    step(8'h00, 1'b1, 16'h0, 4'h0);
    chk("t4_nt_pc_load_cnt", 32'(c_pc_load), 32'd0);

    // call sequence
    clr_cnt();
    for (int s = 8'h1B; s <= 8'h20; s++) step(8'(s), 1'b1, 16'h0, 4'h0);
    step(8'h00, 1'b1, 16'h0, 4'h0);
    chk("t5_sp_dec_cnt", 32'(c_sp_dec), 32'd2);
    chk("t5_mem_we_cnt", 32'(c_mem_we), 32'd2);
    chk("t5_pc_load_cnt", 32'(c_pc_load), 32'd1);

    // asynchronous reset during a pop stall
    step(8'h17, 1'b1, 16'h0, 4'h0);
    step(8'h18, 1'b1, 16'h0, 4'h0);
    step(8'h19, 1'b0, 16'h0, 4'h0);
    step(8'h19, 1'b0, 16'h0, 4'h0);
    chk("t6_pre_state", 32'(state), 32'h18);
    next_state = 8'h19; mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_state", 32'(state), 32'h00);
    chk("t6_strobes", 32'(dut_str), 32'h0);
    chk("t6_instr", 32'(instr), 32'h0);
    chk("t6_status", 32'(status_reg), 32'h0);
    m_state = 8'h00; m_instr = 16'h0; m_status = 4'h0;
    @(posedge clk); #1;
    chk("t6_hold_state", 32'(state), 32'h00);
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) ns = 8'($urandom_range(0, 255));
      else ns = 8'($urandom_range(0, 8'h34));
      step(ns, ($urandom_range(0, 3) != 0), 16'($urandom), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_seq.md
# cpu_ctrl_seq

Sequential half of the 16-bit CPU control unit. Registers the 8-bit control state chosen by the combinational next-state decoder, and holds the instruction register (IR) and the status flags (N,P,Z,C) that the decoder consumes. Decodes the current state into datapath strobes. Stalls the FSM on memory states until the memory acknowledges.

## Interface
Parameters:
- `STATE_W`, default 8: width of the state encoding.
- `INSTR_W`, default 16: instruction width.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset. One clock, `clk`. Reset is asynchronous and active-low.
- `next_state` in 8: next-state decoder output.
- `mem_rdata` in 16: memory read data.
- `mem_ready` in 1: memory acknowledge for the current request.
- `alu_flags` in 4: {N,P,Z,C} from the ALU, valid in flag-update states.
- `state` out 8: registered state; feeds the decoder.
- `instr` out 16: IR; feeds the decoder and the datapath.
- `status_reg` out 4: {N,P,Z,C}; feeds the decoder.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write.
- `ir_load` out 1: IR capture strobe (debug/visibility).
- `pc_inc` out 1: PC increment.
- `pc_load` out 1: PC load.
- `rf_we` out 1: register-file write.
- `sp_inc` out 1: stack-pointer increment.
- `sp_dec` out 1: stack-pointer decrement.
- `alu_op` out 2: 00 pass, 01 add, 10 sub, 11 xor.

## Operation
**Reset.** Asynchronous. Forces:
- `state`=0x00, `instr`=0x0000, `status_reg`=0000.
- All strobes 0 and `alu_op`=00.

**Memory states.** 0x0F, 0x02, 0x13–0x16, 0x17–0x1A, 0x1B–0x20, 0x21–0x24. In these states `mem_req`=1.
- `mem_we`=1 in push 0x15 and call 0x1D/0x1F only.
- Stall rule: in a memory state with `mem_ready`=0, `state`, `instr` and `status_reg` hold. All strobes other than `mem_req`/`mem_we` are suppressed.
- Otherwise `state` ← `next_state` every cycle.

**Fetch.**
- In state 0x0F with `mem_ready`=1: IR ← `mem_rdata`, `ir_load`=1, `pc_inc`=1.
- IR changes only in this case.

**Strobe decode** (Moore, from `state` only, gated by the stall rule):
- 0x02 load: `rf_we`=1 on the ready cycle.
- 0x03 mov: `rf_we`.
- 0x09/0x0A/0x0B: `alu_op`=01, `rf_we` in 0x0B.
- 0x06/0x07/0x08: `alu_op`=10, `rf_we` in 0x08.
- 0x0C/0x0D/0x0E: `alu_op`=11, `rf_we` in 0x0E.
- 0x26/0x27 compare: `alu_op`=10, no `rf_we`.
- 0x04 ldpc: `rf_we`.
- 0x05 branch: `pc_load`.
- Conditional-branch taken states 0x2A/0x2E/0x32: `pc_load`.
- Push: `sp_dec` in 0x16.
- Pop: `sp_inc` in 0x17, `rf_we` in 0x1A.
- Call: `sp_dec` in 0x1C and 0x1E, `pc_load` in 0x20.
- Ret: `sp_inc` in 0x21 and 0x23, `pc_load` in 0x24.
- All other states: strobes 0.

**Flags.**
- `status_reg` ← `alu_flags` at the end of 0x0B, 0x08, 0x0E and 0x27. It holds otherwise.
- Bit order is fixed: [3]=N, [2]=P, [1]=Z, [0]=C.

**Unknown states.** Any state not listed drives all strobes 0. The FSM simply follows `next_state`; the decoder returns 0x00.

## Timing
- Registered state and IR. Strobes are combinational from `state` and `mem_ready`, valid in the same cycle.
- Fetch latency: state 0x00 → 0x0F → 0x01 is 3 cycles with `mem_ready` tied high. Each low cycle of `mem_ready` in 0x0F adds one cycle.
- `mem_ready` is sampled only in memory states and ignored elsewhere.
- Flag update and the `rf_we` of the same state take effect on the same edge.
- A conditional-branch decision in 0x29/0x2D/0x31 uses `status_reg` as registered at the start of that cycle.
- Reset asserted mid-instruction (including during a stall) returns to 0x00 immediately. No partial writes follow, because strobes drop combinationally.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - `localparam`s for every state code (S_FETCH0=0x00, S_FETCH1=0x0F, S_EXEC=0x01, …, S_BRHI4=0x34).
  - The `alu_op` encodings.
  - Status bit indices.
- These same constants are used by the next-state decoder.
- One sub-module, `ctrl_strobe_dec`: purely combinational state→strobe decode. It keeps the register file separate from the decode.

## Test plan
1. Reset then release, `mem_ready`=1, `mem_rdata`=0x2123 → `state` 0x00, 0x0F, 0x01, 0x09 on successive cycles; `instr`=0x2123 after 0x0F; `pc_inc` high exactly once.
2. In 0x0F hold `mem_ready`=0 for 3 cycles → `state` stays 0x0F for 4 cycles total; `ir_load`/`pc_inc` only on the ready cycle; IR unchanged before that.
3. Add sequence with `alu_flags`=4'b0010 → `alu_op`=01 for 3 cycles; `rf_we` only in 0x0B; `status_reg`=0010 after 0x0B.
4. With Z=1, opcode 0xD (BREQ) → states 0x29, 0x2A, 0x2C, 0x2B, 0x00; `pc_load` in 0x2A only. With Z=0 → 0x29, 0x2B, 0x00; no `pc_load`.
5. Call sequence with `mem_ready`=1 → `sp_dec` in 0x1C and 0x1E; `mem_we` in 0x1D and 0x1F; `pc_load` in 0x20.
6. Assert `rst_n`=0 asynchronously mid-stall in pop state 0x18 → `state`=0x00, all strobes 0 within the same cycle; `status_reg` and `instr` cleared.
